// File: rtl/mult32_seq_pkg.sv
// Shared widths, FSM state encodings and the final-count constant for mult32_seq.
package mult32_pkg;

  localparam int MULT_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = 5'd31;

endpackage

// File: rtl/mult32_seq_add32.sv
// Partial-product adder for mult32_seq: W-bit sum with carry-out.
module add32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult32_seq.sv
// Sequential shift-add 32x32 multiplier with start/busy/done handshake.
// Optional signed mode is enabled by defining MULT32_SIGNED_EN.
module mult32_seq
  import mult32_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P_hi,
  output logic [WIDTH-1:0] P_lo
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic               neg_q;

  logic [WIDTH-1:0]   a_cap;
  logic [WIDTH-1:0]   b_cap;
  logic               neg_cap;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   part_hi;
  logic               part_c;
  logic [2*WIDTH-1:0] step_prod;
  logic [2*WIDTH-1:0] final_prod;

`ifdef MULT32_SIGNED_EN
  // Signed requests multiply magnitudes; the sign is reapplied on the last step.
  always_comb begin
    a_cap   = A;
    b_cap   = B;
    neg_cap = 1'b0;
    if (sgn) begin
      if (A[WIDTH-1]) a_cap = -A;
      if (B[WIDTH-1]) b_cap = -B;
      neg_cap = A[WIDTH-1] ^ B[WIDTH-1];
    end
  end
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_cap      = A;
  assign b_cap      = B;
  assign neg_cap    = 1'b0;
`endif

  add32 #(.W(WIDTH)) u_add (
    .a   (P_hi),
    .b   (mcand),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    part_c  = 1'b0;
    part_hi = P_hi;
    if (P_lo[0]) begin
      part_c  = add_cout;
      part_hi = add_sum;
    end
  end

  // The 65-bit {carry, hi, lo} shifted right by one keeps the low 64 bits.
  assign step_prod  = {part_c, part_hi, P_lo[WIDTH-1:1]};
  assign final_prod = neg_q ? (~step_prod + ONE) : step_prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      neg_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P_hi  <= '0;
      P_lo  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a_cap;
            P_hi  <= '0;
            P_lo  <= b_cap;
            cnt   <= '0;
            neg_q <= neg_cap;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            {P_hi, P_lo} <= final_prod;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            {P_hi, P_lo} <= step_prod;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
